// File: rtl/vga_rect_ctrlmod.sv
// vga_rect_ctrlmod: frame-synchronous position/colour controller for the VGA rectangle
module vga_rect_ctrlmod #(
  parameter logic [9:0] SC    = 10'd640,
  parameter logic [9:0] SQ    = 10'd480,
  parameter logic [9:0] XSIZE = 10'd128,
  parameter logic [9:0] YSIZE = 10'd128,
  parameter logic [9:0] XINIT = 10'd256,
  parameter logic [9:0] YINIT = 10'd176,
  parameter logic [9:0] STEP  = 10'd4,
  parameter logic [9:0] ASTEP = 10'd2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iFrame,
  input  logic        iMode,
  input  logic        iReq,
  input  logic [1:0]  iDir,
  output logic        oAck,
  input  logic        iColorWe,
  input  logic [15:0] iColor,
  output logic [9:0]  oXOFF,
  output logic [9:0]  oYOFF,
  output logic [15:0] oColor,
  output logic        oUpdate
);
  localparam logic [9:0] XMAX = SC - XSIZE;
  localparam logic [9:0] YMAX = SQ - YSIZE;

  typedef enum logic [1:0] {IDLE, PEND, AUTO} state_t;
  state_t      state;
  logic [1:0]  dir_q;
  logic        dx, dy;
  logic [15:0] shadow;
  logic [9:0]  man_x, man_y, auto_x, auto_y;
  logic        x_hit, y_hit, ndx, ndy;

  // next positions for a latched manual step and for one bounce step, all clamped
  always_comb begin
    man_x  = (dir_q == 2'b11) ? ((oXOFF + STEP > XMAX) ? XMAX : oXOFF + STEP) :
             (dir_q == 2'b10) ? ((oXOFF < STEP) ? 10'd0 : oXOFF - STEP) : oXOFF;
    man_y  = (dir_q == 2'b01) ? ((oYOFF + STEP > YMAX) ? YMAX : oYOFF + STEP) :
             (dir_q == 2'b00) ? ((oYOFF < STEP) ? 10'd0 : oYOFF - STEP) : oYOFF;
    x_hit  = dx ? (oXOFF + ASTEP >= XMAX) : (oXOFF <= ASTEP);
    y_hit  = dy ? (oYOFF + ASTEP >= YMAX) : (oYOFF <= ASTEP);
    auto_x = dx ? (x_hit ? XMAX : oXOFF + ASTEP) : (x_hit ? 10'd0 : oXOFF - ASTEP);
    auto_y = dy ? (y_hit ? YMAX : oYOFF + ASTEP) : (y_hit ? 10'd0 : oYOFF - ASTEP);
    ndx    = x_hit ? ~dx : dx;
    ndy    = y_hit ? ~dy : dy;
  end

  // control FSM; position and colour only change on a frame pulse
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      dir_q   <= 2'b00;
      dx      <= 1'b1;
      dy      <= 1'b1;
      shadow  <= 16'hFFFF;
      oColor  <= 16'hFFFF;
      oXOFF   <= XINIT;
      oYOFF   <= YINIT;
      oAck    <= 1'b0;
      oUpdate <= 1'b0;
    end else begin
      oAck    <= 1'b0;
      oUpdate <= 1'b0;
      if (iColorWe) shadow <= iColor;
      if (iFrame) oColor <= shadow;
      case (state)
        IDLE: begin
          if (iMode) state <= AUTO;
          else if (iReq) begin
            dir_q <= iDir;
            oAck  <= 1'b1;
            state <= PEND;
          end
        end
        PEND: begin
          if (iFrame) begin
            oXOFF   <= man_x;
            oYOFF   <= man_y;
            oUpdate <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          if (iFrame) begin
            oXOFF   <= auto_x;
            oYOFF   <= auto_y;
            dx      <= ndx;
            dy      <= ndy;
            oUpdate <= 1'b1;
          end
          if (!iMode) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_rect_ctrlmod.sv
// tb_vga_rect_ctrlmod: scoreboard bench for the rectangle controller
module tb_vga_rect_ctrlmod;
  logic        CLOCK = 0, RESET = 0;
  logic        iFrame = 0, iMode = 0, iReq = 0, iColorWe = 0;
  logic [1:0]  iDir = 0;
  logic [15:0] iColor = 0;
  logic        oAck, oUpdate;
  logic [9:0]  oXOFF, oYOFF;
  logic [15:0] oColor;

  vga_rect_ctrlmod dut (
    .CLOCK(CLOCK), .RESET(RESET), .iFrame(iFrame), .iMode(iMode), .iReq(iReq),
    .iDir(iDir), .oAck(oAck), .iColorWe(iColorWe), .iColor(iColor),
    .oXOFF(oXOFF), .oYOFF(oYOFF), .oColor(oColor), .oUpdate(oUpdate)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {int x; int y; int c;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int ex, ey, sh, edx, edy;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  // scoreboard monitor: every commit pulse must match the oldest expectation
  always @(negedge CLOCK) begin
    if (RESET && oUpdate) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_update: got x=%0d y=%0d want none", oXOFF, oYOFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(oXOFF) != e.x || int'(oYOFF) != e.y || int'(oColor) != e.c) begin
          bad++;
          $display("FAIL commit: got x=%0d y=%0d c=%0h want x=%0d y=%0d c=%0h",
                   oXOFF, oYOFF, oColor, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic model_reset();
    ex = 256; ey = 176; sh = 'hFFFF; edx = 1; edy = 1;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 0; iReq = 0; iMode = 0; iFrame = 0; iColorWe = 0;
    repeat (2) @(negedge CLOCK);
    RESET = 1;
    model_reset();
  endtask

  task automatic frame();
    @(negedge CLOCK); iFrame = 1;
    @(negedge CLOCK); iFrame = 0;
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin @(negedge CLOCK); n++; end while (!oAck && n < 8);
    iReq = 0;
    chk("ack", int'(oAck), 1);
  endtask

  task automatic move(input logic [1:0] d);
    @(negedge CLOCK); iReq = 1; iDir = d;
    wait_ack();
    chk("hold_x", int'(oXOFF), ex);
    case (d)
      2'b11: ex = (ex + 4 > 512) ? 512 : ex + 4;
      2'b10: ex = (ex < 4) ? 0 : ex - 4;
      2'b01: ey = (ey + 4 > 352) ? 352 : ey + 4;
      default: ey = (ey < 4) ? 0 : ey - 4;
    endcase
    q.push_back('{ex, ey, sh});
    frame();
  endtask

  task automatic astep(inout int p, inout int d, input int mx);
    if (d > 0) begin
      if (p + 2 >= mx) begin p = mx; d = -1; end else p += 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; end else p -= 2;
    end
  endtask

  task automatic auto_frame(input logic m);
    astep(ex, edx, 512);
    astep(ey, edy, 352);
    q.push_back('{ex, ey, sh});
    @(negedge CLOCK); iFrame = 1; iMode = m;
    @(negedge CLOCK); iFrame = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    model_reset();
    repeat (3) @(negedge CLOCK);
    RESET = 1;
    @(negedge CLOCK);
    chk("rst_x", int'(oXOFF), 256);
    chk("rst_y", int'(oYOFF), 176);
    chk("rst_c", int'(oColor), 'hFFFF);
    chk("rst_ack", int'(oAck), 0);
    chk("rst_upd", int'(oUpdate), 0);
    // single right step
    move(2'b11);
    chk("x260", int'(oXOFF), 260);
    // clamps
    repeat (65) move(2'b11);
    chk("x_max", int'(oXOFF), 512);
    repeat (129) move(2'b10);
    chk("x_zero", int'(oXOFF), 0);
    move(2'b10);
    chk("x_stay0", int'(oXOFF), 0);
    move(2'b01);
    move(2'b00);
    chk("y_back", int'(oYOFF), 176);
    // colour shadow and coincident write/commit
    @(negedge CLOCK); iColorWe = 1; iColor = 16'h001F;
    @(negedge CLOCK); iColorWe = 0; sh = 'h001F;
    frame();
    chk("color_1f", int'(oColor), 'h001F);
    @(negedge CLOCK); iColorWe = 1; iColor = 16'hF800; iFrame = 1;
    @(negedge CLOCK); iColorWe = 0; iFrame = 0;
    chk("color_old", int'(oColor), 'h001F);
    sh = 'hF800;
    frame();
    chk("color_f800", int'(oColor), 'hF800);
    // request and frame together: acked but applied only on next frame
    @(negedge CLOCK); iReq = 1; iDir = 2'b11; iFrame = 1;
    @(negedge CLOCK); iFrame = 0; iReq = 0;
    chk("rf_ack", int'(oAck), 1);
    chk("rf_noupd", int'(oUpdate), 0);
    chk("rf_hold", int'(oXOFF), ex);
    ex = ex + 4;
    q.push_back('{ex, ey, sh});
    frame();
    chk("rf_applied", int'(oXOFF), ex);
    // request with mode: no ack, goes to auto
    @(negedge CLOCK); iReq = 1; iMode = 1;
    acks = 0;
    repeat (4) begin @(negedge CLOCK); acks += int'(oAck); end
    iReq = 0;
    chk("mode_noack", acks, 0);
    auto_frame(1'b0);
    move(2'b01);
    // bounce from reset
    do_reset();
    @(negedge CLOCK); iMode = 1;
    for (int i = 1; i <= 129; i++) begin
      auto_frame(i == 129 ? 1'b0 : 1'b1);
      if (i == 88) chk("auto_y352", int'(oYOFF), 352);
      if (i == 128) chk("auto_x512", int'(oXOFF), 512);
      if (i == 129) chk("auto_x510", int'(oXOFF), 510);
    end
    chk("auto_y270", int'(oYOFF), 270);
    move(2'b10);
    // reset while pending
    @(negedge CLOCK); iReq = 1; iDir = 2'b11;
    wait_ack();
    @(negedge CLOCK); RESET = 0;
    @(negedge CLOCK);
    chk("prst_x", int'(oXOFF), 256);
    chk("prst_y", int'(oYOFF), 176);
    chk("prst_c", int'(oColor), 'hFFFF);
    chk("prst_ack", int'(oAck), 0);
    RESET = 1;
    model_reset();
    frame();
    chk("prst_noupd", int'(oUpdate), 0);
    chk("prst_hold", int'(oXOFF), 256);
    repeat (3) @(negedge CLOCK);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
